// File: rtl/rc5_pkg.sv
// Shared RC5-32 definitions: FSM encoding, magic constants, default round count
// and 32-bit rotate helpers.
package rc5_pkg;

  localparam int unsigned RC5_ROUNDS = 12;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  typedef enum logic [2:0] {
    StIdle,
    StKInit,
    StKMix,
    StDRound,
    StDFinal
  } state_t;

  // (0 - sh) mod 32 is the complementary shift; sh == 0 degenerates to x | x.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] sh);
    return (x << sh) | (x >> (5'd0 - sh));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] sh);
    return (x >> sh) | (x << (5'd0 - sh));
  endfunction

endpackage

// File: rtl/rc5_key_sched.sv
// RC5-32 key expansion: fills S with the P/Q ramp, then runs the 3*T mixing pass.
// Owns S and L storage; S is read combinationally through two ports.
module rc5_key_sched
  import rc5_pkg::*;
#(
  parameter int unsigned ROUNDS = RC5_ROUNDS,
  localparam int unsigned T = 2 * ROUNDS + 2,
  localparam int unsigned IW = $clog2(T)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key,
  input  logic          start,
  input  logic          init_en,
  input  logic          mix_en,
  output logic          init_last,
  output logic          done,
  input  logic [IW-1:0] rd_addr_lo,
  input  logic [IW-1:0] rd_addr_hi,
  output logic [31:0]   rd_data_lo,
  output logic [31:0]   rd_data_hi
);

  localparam int unsigned KW = $clog2(3 * T);

  logic [31:0]   s_q [T];
  logic [31:0]   l_q [4];
  logic [IW-1:0] i_q;
  logic [1:0]    j_q;
  logic [KW-1:0] k_q;
  logic [31:0]   a_q, b_q, init_q;

  logic [31:0]   mix_a, mix_ab, mix_b;
  logic [IW-1:0] i_next;

  always_comb begin
    mix_a  = rotl32(s_q[i_q] + a_q + b_q, 5'd3);
    mix_ab = mix_a + b_q;
    mix_b  = rotl32(l_q[j_q] + mix_ab, mix_ab[4:0]);
    i_next = (i_q == IW'(T - 1)) ? '0 : i_q + 1'b1;
  end

  assign init_last  = init_en && (i_q == IW'(T - 1));
  assign done       = mix_en && (k_q == KW'(3 * T - 1));
  assign rd_data_lo = s_q[rd_addr_lo];
  assign rd_data_hi = s_q[rd_addr_hi];

  // i wraps to 0 after the last init write, so mixing starts at S[0] for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < int'(T); n++) s_q[n] <= '0;
      for (int n = 0; n < 4; n++) l_q[n] <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      init_q <= P32;
    end else if (start) begin
      for (int n = 0; n < 4; n++) l_q[n] <= key[32*n +: 32];
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      init_q <= P32;
    end else if (init_en) begin
      s_q[i_q] <= init_q;
      init_q   <= init_q + Q32;
      i_q      <= i_next;
    end else if (mix_en) begin
      s_q[i_q] <= mix_a;
      l_q[j_q] <= mix_b;
      a_q      <= mix_a;
      b_q      <= mix_b;
      i_q      <= i_next;
      j_q      <= j_q + 1'b1;
      k_q      <= k_q + 1'b1;
    end
  end

endmodule

// File: rtl/rc5_dec_core.sv
// RC5-32 decryption core: one round per cycle after an on-chip key schedule.
// Define RC5_DEC_ZEROIZE_DOUT_EN to force dout to zero whenever dout_en is low.
module rc5_dec_core
  import rc5_pkg::*;
#(
  parameter int unsigned ROUNDS = RC5_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         key_en,
  output logic         key_ok,
  input  logic [63:0]  din,
  input  logic         din_en,
  output logic [63:0]  dout,
  output logic         dout_en
);

  localparam int unsigned T = 2 * ROUNDS + 2;
  localparam int unsigned IW = $clog2(T);

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [IW-1:0] r_q, r_d;
  logic [63:0]   dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic          key_ok_q, key_ok_d;

  logic          init_last, sched_done;
  logic [IW-1:0] addr_lo, addr_hi;
  logic [31:0]   s_lo, s_hi;
  logic [31:0]   rnd_a, rnd_b, fin_a, fin_b;

  // r counts down to 0, so DFINAL naturally addresses S[0]/S[1].
  assign addr_lo = {r_q[IW-2:0], 1'b0};
  assign addr_hi = {r_q[IW-2:0], 1'b1};

  rc5_key_sched #(
    .ROUNDS(ROUNDS)
  ) u_key_sched (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .start     (key_en),
    .init_en   (state_q == StKInit),
    .mix_en    (state_q == StKMix),
    .init_last (init_last),
    .done      (sched_done),
    .rd_addr_lo(addr_lo),
    .rd_addr_hi(addr_hi),
    .rd_data_lo(s_lo),
    .rd_data_hi(s_hi)
  );

  always_comb begin
    rnd_b = rotr32(b_q - s_hi, a_q[4:0]) ^ a_q;
    rnd_a = rotr32(a_q - s_lo, rnd_b[4:0]) ^ rnd_b;
    fin_b = b_q - s_hi;
    fin_a = a_q - s_lo;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;
    key_ok_d  = key_ok_q;
    if (key_en) begin
      // Rekey wins over everything, including an in-flight block.
      state_d  = StKInit;
      key_ok_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (din_en && key_ok_q) begin
            a_d     = din[31:0];
            b_d     = din[63:32];
            r_d     = IW'(ROUNDS);
            state_d = StDRound;
          end
        end
        StKInit: begin
          if (init_last) state_d = StKMix;
        end
        StKMix: begin
          if (sched_done) begin
            state_d  = StIdle;
            key_ok_d = 1'b1;
          end
        end
        StDRound: begin
          a_d = rnd_a;
          b_d = rnd_b;
          r_d = r_q - 1'b1;
          if (r_q == IW'(1)) state_d = StDFinal;
        end
        StDFinal: begin
          a_d       = fin_a;
          b_d       = fin_b;
          dout_d    = {fin_b, fin_a};
          dout_en_d = 1'b1;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      key_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      key_ok_q  <= key_ok_d;
    end
  end

  assign key_ok  = key_ok_q;
  assign dout_en = dout_en_q;

`ifdef RC5_DEC_ZEROIZE_DOUT_EN
  assign dout = dout_en_q ? dout_q : '0;
`else
  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_rc5_dec_core.sv
// Directed bench for rc5_dec_core using the published RC5-32/12/16 vectors.
module tb_rc5_dec_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic         key_en = 1'b0;
  logic         key_ok;
  logic [63:0]  din = '0;
  logic         din_en = 1'b0;
  logic [63:0]  dout;
  logic         dout_en;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [63:0]  CT0  = 64'h6D8F4B15_EEDBA521;
  localparam logic [127:0] KEY2 = 128'h91CEA910_01A55563_51B241BE_19465F91;
  localparam logic [63:0]  CT2  = 64'h52892B5B_AC13C0F7;
  localparam logic [63:0]  PT2  = 64'h6D8F4B15_EEDBA521;

  always #5 clk = ~clk;

  rc5_dec_core #(
    .ROUNDS(12)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .key_en (key_en),
    .key_ok (key_ok),
    .din    (din),
    .din_en (din_en),
    .dout   (dout),
    .dout_en(dout_en)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Pulses key_en (optionally with din_en); returns sample index of first key_ok and dout_en count.
  task automatic run_key(input logic [127:0] k, input logic with_din,
                         output int cycles, output int strobes);
    key = k; key_en = 1'b1; din_en = with_din;
    @(posedge clk); #1;
    key_en = 1'b0; din_en = 1'b0;
    cycles = -1; strobes = 0;
    for (int n = 1; n <= 200; n++) begin
      if (dout_en) strobes++;
      if (key_ok) begin cycles = n; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_decrypt(input logic [63:0] d, output int lat, output logic [63:0] q);
    din = d; din_en = 1'b1;
    @(posedge clk); #1;
    din_en = 1'b0;
    lat = -1; q = '0;
    for (int n = 1; n <= 40; n++) begin
      if (dout_en) begin lat = n; q = dout; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic count_strobes(input int ncyc, output int s);
    s = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (dout_en) s++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (key_ok !== 1'b0) begin n_fail++; $display("FAIL reset_key_ok: got %b want 0", key_ok); end
    n_checks++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL reset_dout_en: got %b want 0", dout_en); end
    n_checks++; if (dout !== 64'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
  endtask

  task automatic test_din_without_key();
    int s;
    din = CT0; din_en = 1'b1;
    @(posedge clk); #1;
    din_en = 1'b0;
    count_strobes(30, s);
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL nokey_din_ignored: got %0d strobes want 0", s); end
    n_checks++; if (key_ok !== 1'b0) begin n_fail++; $display("FAIL nokey_key_ok: got %b want 0", key_ok); end
  endtask

  task automatic test_key_schedule();
    int c, s;
    run_key('0, 1'b0, c, s);
    n_checks++; if (c !== 105) begin n_fail++; $display("FAIL key_sched_latency: got %0d want 105", c); end
  endtask

  task automatic test_decrypt_zero();
    int lat;
    logic [63:0] q;
    run_decrypt(CT0, lat, q);
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL zero_latency: got %0d want 14", lat); end
    n_checks++; if (q !== 64'h0) begin n_fail++; $display("FAIL zero_dout: got %h want 0", q); end
    @(posedge clk); #1;
    n_checks++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_width: got %b want 0", dout_en); end
  endtask

  task automatic test_din_during_dround();
    int lat, s;
    logic [63:0] q;
    din = CT0; din_en = 1'b1;
    @(posedge clk); #1;
    din_en = 1'b0;
    lat = -1; s = 0; q = '0;
    for (int n = 1; n <= 50; n++) begin
      if (n == 3) begin din = 64'hDEADBEEF_01234567; din_en = 1'b1; end
      else din_en = 1'b0;
      if (dout_en) begin
        s++;
        if (lat < 0) begin lat = n; q = dout; end
      end
      @(posedge clk); #1;
    end
    din_en = 1'b0;
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL busy_latency: got %0d want 14", lat); end
    n_checks++; if (q !== 64'h0) begin n_fail++; $display("FAIL busy_dout: got %h want 0", q); end
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL busy_strobes: got %0d want 1", s); end
  endtask

  task automatic test_key_abort();
    int c, s;
    din = CT0; din_en = 1'b1;
    @(posedge clk); #1;
    din_en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    run_key(KEY2, 1'b0, c, s);
    n_checks++; if (c !== 105) begin n_fail++; $display("FAIL abort_key_latency: got %0d want 105", c); end
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL abort_no_dout_en: got %0d strobes want 0", s); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [63:0] q1, q2, hold;
    run_decrypt(CT2, lat1, q1);
    run_decrypt(CT2, lat2, q2);
    n_checks++; if (lat1 !== 14) begin n_fail++; $display("FAIL b2b_latency1: got %0d want 14", lat1); end
    n_checks++; if (q1 !== PT2) begin n_fail++; $display("FAIL b2b_dout1: got %h want %h", q1, PT2); end
    n_checks++; if (lat2 !== 14) begin n_fail++; $display("FAIL b2b_latency2: got %0d want 14", lat2); end
    n_checks++; if (q2 !== PT2) begin n_fail++; $display("FAIL b2b_dout2: got %h want %h", q2, PT2); end
    @(posedge clk); #1;
`ifdef RC5_DEC_ZEROIZE_DOUT_EN
    hold = 64'h0;
`else
    hold = PT2;
`endif
    n_checks++; if (dout !== hold) begin n_fail++; $display("FAIL b2b_dout_idle: got %h want %h", dout, hold); end
  endtask

  task automatic test_reset_mid_kmix();
    int c, s, lat;
    logic [63:0] q;
    key = '0; key_en = 1'b1;
    @(posedge clk); #1;
    key_en = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_checks++; if (key_ok !== 1'b0) begin n_fail++; $display("FAIL rst_key_ok: got %b want 0", key_ok); end
    n_checks++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL rst_dout_en: got %b want 0", dout_en); end
    n_checks++; if (dout !== 64'h0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", dout); end
    @(posedge clk); #1;
    rst = 1'b0;
    din = CT0; din_en = 1'b1;
    @(posedge clk); #1;
    din_en = 1'b0;
    count_strobes(30, s);
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL rst_din_ignored: got %0d strobes want 0", s); end
    run_key('0, 1'b0, c, s);
    n_checks++; if (c !== 105) begin n_fail++; $display("FAIL rst_rekey_latency: got %0d want 105", c); end
    run_decrypt(CT0, lat, q);
    n_checks++; if (lat !== 14 || q !== 64'h0) begin
      n_fail++; $display("FAIL rst_decrypt: got lat %0d dout %h want lat 14 dout 0", lat, q);
    end
  endtask

  task automatic test_key_din_same_cycle();
    int c, s, lat;
    logic [63:0] q;
    din = CT2;
    run_key(KEY2, 1'b1, c, s);
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL same_no_dout_en: got %0d strobes want 0", s); end
    n_checks++; if (c !== 105) begin n_fail++; $display("FAIL same_key_latency: got %0d want 105", c); end
    run_decrypt(CT2, lat, q);
    n_checks++; if (q !== PT2) begin n_fail++; $display("FAIL same_decrypt: got %h want %h", q, PT2); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_din_without_key();
    test_key_schedule();
    test_decrypt_zero();
    test_din_during_dround();
    test_key_abort();
    test_back_to_back();
    test_reset_mid_kmix();
    test_key_din_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
